rv32i_pipe_core: RTL and testbench

- Three-stage in-order RV32I integer core: fetch -> decode/register-read -> execute/memory/retire.
- Instruction bus is a read-only valid/ready port to the code memory.
- Data bus is a single-beat valid/ready load/store port.
- Exposes x5, x6, x7 and x10 for bench observation; sits between the code ROM and the data memory/peripheral bus.

---
 rtl/rv32_pkg.sv | 80 ++++++++
 rtl/rv32_decode.sv | 112 +++++++++++
 rtl/rv32_execute.sv | 96 +++++++++
 rtl/rv32i_pipe_core.sv | 85 ++++++++
 tb/tb_rv32i_pipe_core.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU op encoding, immediate helpers, D/E bundle.
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;
   localparam logic [2:0] F3_SR   = 3'd5;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] tgt;
      alu_op_e     op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        wr;
      logic        ld;
      logic        st;
      logic        br;
      logic        jal;
      logic        jalr;
      logic        opa_pc;
      logic        use_imm;
   } de_t;

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return {{21{i[31]}}, i[30:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      return {{21{i[31]}}, i[30:25], i[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] i);
      return {i[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv32_decode.sv
// Decode / register-read stage: register file, immediates, hazard stall and the D/E register.
module rv32_decode
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fd_valid,
   input  logic [31:0] fd_instr,
   input  logic [31:0] fd_pc,
   input  logic        hold,
   input  logic        flush,
   input  logic        rt_wr,
   input  logic [4:0]  rt_rd,
   input  logic [31:0] rt_res,
   output logic        stall,
   output de_t         de,
   output logic [31:0] r5,
   output logic [31:0] r6,
   output logic [31:0] r7,
   output logic [31:0] r10
);

   logic [31:0] regs [32];
   logic [4:0]  rs1, rs2;
   logic [31:0] rv1, rv2;
   logic        use1, use2;
   de_t         d;

   assign rs1 = fd_instr[19:15];
   assign rs2 = fd_instr[24:20];
   assign r5  = regs[5];
   assign r6  = regs[6];
   assign r7  = regs[7];
   assign r10 = regs[10];

   // Register read with write-first bypass from the retire port
   always_comb begin
      rv1 = regs[rs1];
      rv2 = regs[rs2];
      if (rt_wr && rt_rd == rs1) rv1 = rt_res;
      if (rt_wr && rt_rd == rs2) rv2 = rt_res;
      if (rs1 == 5'd0) rv1 = '0;
      if (rs2 == 5'd0) rv2 = '0;
   end

   // Instruction field decode into the D/E bundle
   always_comb begin
      d         = '0;
      use1      = 1'b0;
      use2      = 1'b0;
      d.valid   = 1'b1;
      d.pc      = fd_pc;
      d.a       = rv1;
      d.b       = rv2;
      d.rd      = fd_instr[11:7];
      d.f3      = fd_instr[14:12];
      d.op      = ALU_ADD;
      d.use_imm = 1'b1;
      d.imm     = imm_i(fd_instr);
      case (fd_instr[6:0])
         OPC_OP: begin
            d.op = alu_decode(d.f3, fd_instr[30]);
            d.use_imm = 1'b0;
            d.wr = 1'b1; use1 = 1'b1; use2 = 1'b1;
         end
         OPC_OP_IMM: begin
            d.op = alu_decode(d.f3, fd_instr[30] && d.f3 == F3_SR);
            d.wr = 1'b1; use1 = 1'b1;
         end
         OPC_LOAD:   begin d.ld = 1'b1; d.wr = 1'b1; use1 = 1'b1; end
         OPC_STORE:  begin d.st = 1'b1; d.imm = imm_s(fd_instr); use1 = 1'b1; use2 = 1'b1; end
         OPC_BRANCH: begin d.br = 1'b1; d.imm = imm_b(fd_instr); use1 = 1'b1; use2 = 1'b1; end
         OPC_JAL:    begin d.jal = 1'b1; d.wr = 1'b1; d.imm = imm_j(fd_instr); end
         OPC_JALR:   begin d.jalr = 1'b1; d.wr = 1'b1; use1 = 1'b1; end
         OPC_LUI:    begin d.op = ALU_PASS_B; d.imm = imm_u(fd_instr); d.wr = 1'b1; end
         OPC_AUIPC:  begin d.opa_pc = 1'b1; d.imm = imm_u(fd_instr); d.wr = 1'b1; end
         default:    ;
      endcase
      d.tgt = fd_pc + d.imm;
   end

   // RAW hazard against the instructions in D/E and retire
   always_comb begin
      stall = 1'b0;
      if (de.valid && de.wr && de.rd != 5'd0 &&
          ((use1 && de.rd == rs1) || (use2 && de.rd == rs2)))
         stall = fd_valid;
      if (rt_wr && rt_rd != 5'd0 &&
          ((use1 && rt_rd == rs1) || (use2 && rt_rd == rs2)))
         stall = fd_valid;
   end

   // Register file write from the retire register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rt_wr && rt_rd != 5'd0) begin
         regs[rt_rd] <= rt_res;
      end
   end

   // D/E register: hold on memory stall, bubble on flush or hazard
   always_ff @(posedge clk) begin
      if (rst) begin
         de.valid <= 1'b0;
      end else if (!hold) begin
         if (flush || stall || !fd_valid) de.valid <= 1'b0;
         else                             de <= d;
      end
   end

endmodule

// File: rtl/rv32_execute.sv
// Execute / memory stage: ALU, branch resolution, data bus, and the retire register.
module rv32_execute
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  de_t         de,
   output logic [31:0] db_addr,
   output logic [3:0]  db_lanes,
   input  logic [31:0] db_din,
   output logic [31:0] db_dout,
   output logic        db_wr,
   output logic        db_valid,
   input  logic        db_ready,
   output logic        jmp,
   output logic [31:0] jmp_addr,
   output logic        mem_stall,
   output logic        rt_wr,
   output logic [4:0]  rt_rd,
   output logic [31:0] rt_res
);

   logic [31:0] a, b, alu, bsel, wsh, hsh, ldv, res;
   logic [4:0]  sh;
   logic        taken;

   // ALU and branch compare
   always_comb begin
      a  = de.opa_pc ? de.pc : de.a;
      b  = de.use_imm ? de.imm : de.b;
      sh = b[4:0];
      case (de.op)
         ALU_ADD:    alu = a + b;
         ALU_SUB:    alu = a - b;
         ALU_SLL:    alu = a << sh;
         ALU_SLT:    alu = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:   alu = {31'd0, a < b};
         ALU_XOR:    alu = a ^ b;
         ALU_SRL:    alu = a >> sh;
         ALU_SRA:    alu = 32'($signed(a) >>> sh);
         ALU_OR:     alu = a | b;
         ALU_AND:    alu = a & b;
         ALU_PASS_B: alu = b;
         default:    alu = '0;
      endcase
      case (de.f3)
         F3_BEQ:  taken = de.a == de.b;
         F3_BNE:  taken = de.a != de.b;
         F3_BLT:  taken = $signed(de.a) < $signed(de.b);
         F3_BGE:  taken = $signed(de.a) >= $signed(de.b);
         F3_BLTU: taken = de.a < de.b;
         F3_BGEU: taken = de.a >= de.b;
         default: taken = 1'b0;
      endcase
      jmp      = de.valid && (de.jal || de.jalr || (de.br && taken));
      jmp_addr = de.jalr ? {alu[31:1], 1'b0} : de.tgt;
   end

   // Data bus request, store lane steering and load extraction
   always_comb begin
      db_valid  = de.valid && (de.ld || de.st);
      db_wr     = de.st;
      db_addr   = {alu[31:2], 2'b00};
      mem_stall = db_valid && !db_ready;
      case (de.f3[1:0])
         2'b00:   begin db_lanes = 4'b0001 << alu[1:0]; db_dout = {4{de.b[7:0]}}; end
         2'b01:   begin db_lanes = alu[1] ? 4'b1100 : 4'b0011; db_dout = {2{de.b[15:0]}}; end
         default: begin db_lanes = '1; db_dout = de.b; end
      endcase
      bsel = db_din;
      wsh  = bsel >> {alu[1:0], 3'b000};
      hsh  = bsel >> {alu[1], 4'b0000};
      case (de.f3)
         3'd0:    ldv = {{24{wsh[7]}}, wsh[7:0]};
         3'd4:    ldv = {24'd0, wsh[7:0]};
         3'd1:    ldv = {{16{hsh[15]}}, hsh[15:0]};
         3'd5:    ldv = {16'd0, hsh[15:0]};
         default: ldv = bsel;
      endcase
      if (de.jal || de.jalr) res = de.pc + 32'd4;
      else if (de.ld)        res = ldv;
      else                   res = alu;
   end

   // Retire register; a stalled memory access retires only once db_ready arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         rt_wr <= 1'b0;
      end else begin
         rt_wr  <= de.valid && de.wr && !mem_stall;
         rt_rd  <= de.rd;
         rt_res <= res;
      end
   end

endmodule

// File: rtl/rv32i_pipe_core.sv
// Three-stage RV32I core top: fetch stage with one-word hold buffer, decode and execute instances.
module rv32i_pipe_core
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ib_addr,
   input  logic [31:0] ib_din,
   output logic        ib_valid,
   input  logic        ib_ready,
   output logic [31:0] db_addr,
   output logic [3:0]  db_lanes,
   input  logic [31:0] db_din,
   output logic [31:0] db_dout,
   output logic        db_wr,
   output logic        db_valid,
   input  logic        db_ready,
   output logic [31:0] r5,
   output logic [31:0] r6,
   output logic [31:0] r7,
   output logic [31:0] r10
);

   logic [31:0] pc, fd_instr, fd_pc, hb_instr, hb_pc, jmp_addr, rt_res;
   logic        fetch_en, fd_valid, hb_valid, jmp, stall, mem_stall, rt_wr;
   logic        fire, fd_free;
   logic [4:0]  rt_rd;
   de_t         de;

   assign ib_addr  = pc;
   assign ib_valid = fetch_en && !hb_valid;
   assign fire     = ib_valid && ib_ready && !jmp;
   assign fd_free  = !fd_valid || (!stall && !mem_stall);

   // Fetch: a word returned while F/D cannot advance parks in the hold buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         fetch_en <= 1'b0;
         fd_valid <= 1'b0;
         hb_valid <= 1'b0;
      end else begin
         fetch_en <= 1'b1;
         if (jmp) begin
            pc       <= jmp_addr;
            fd_valid <= 1'b0;
            hb_valid <= 1'b0;
         end else begin
            if (fire) pc <= pc + 32'd4;
            if (fd_free) begin
               if (hb_valid) begin
                  fd_instr <= hb_instr;
                  fd_pc    <= hb_pc;
                  hb_valid <= 1'b0;
               end else begin
                  fd_instr <= ib_din;
                  fd_pc    <= pc;
               end
               fd_valid <= hb_valid || fire;
            end else if (fire) begin
               hb_instr <= ib_din;
               hb_pc    <= pc;
               hb_valid <= 1'b1;
            end
         end
      end
   end

   rv32_decode u_decode (
      .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_pc(fd_pc),
      .hold(mem_stall), .flush(jmp), .rt_wr(rt_wr), .rt_rd(rt_rd), .rt_res(rt_res),
      .stall(stall), .de(de), .r5(r5), .r6(r6), .r7(r7), .r10(r10)
   );

   rv32_execute u_execute (
      .clk(clk), .rst(rst), .de(de),
      .db_addr(db_addr), .db_lanes(db_lanes), .db_din(db_din), .db_dout(db_dout),
      .db_wr(db_wr), .db_valid(db_valid), .db_ready(db_ready),
      .jmp(jmp), .jmp_addr(jmp_addr), .mem_stall(mem_stall),
      .rt_wr(rt_wr), .rt_rd(rt_rd), .rt_res(rt_res)
   );

endmodule

// File: tb/tb_rv32i_pipe_core.sv
// Directed bench for rv32i_pipe_core: short programs in a 1-cycle-latency ROM, results checked on the exposed registers and bus.
module tb_rv32i_pipe_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ib_addr, ib_din, db_addr, db_din, db_dout, r5, r6, r7, r10;
   logic        ib_valid, db_wr, db_valid, db_ready;
   logic        ib_ready = 1'b0;
   logic [3:0]  db_lanes;
   logic [31:0] rom [1024];
   logic        rom_en;

   int n_pass = 0, n_total = 0, n_fail = 0;
   int jmp_cnt = 0, rt_cnt = 0, wr_cnt = 0;
   int b_jmp, b_rt, b_wr;
   logic [31:0] last_jmp, wr_addr, wr_dout;
   logic [3:0]  wr_lanes;

   rv32i_pipe_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .ib_addr(ib_addr), .ib_din(ib_din), .ib_valid(ib_valid), .ib_ready(ib_ready),
      .db_addr(db_addr), .db_lanes(db_lanes), .db_din(db_din), .db_dout(db_dout),
      .db_wr(db_wr), .db_valid(db_valid), .db_ready(db_ready),
      .r5(r5), .r6(r6), .r7(r7), .r10(r10)
   );

   always #5 clk = ~clk;

   // ROM: combinational data, ready one cycle after each request is seen
   assign ib_din = rom[ib_addr[11:2]];
   always @(posedge clk) ib_ready <= rom_en && (ib_valid === 1'b1) && !ib_ready;

   // Bus / control-flow monitor
   always @(posedge clk) begin
      if (dut.jmp === 1'b1) begin
         jmp_cnt  <= jmp_cnt + 1;
         last_jmp <= dut.jmp_addr;
      end
      if (dut.rt_wr === 1'b1) rt_cnt <= rt_cnt + 1;
      if (db_valid === 1'b1 && db_ready && db_wr) begin
         wr_cnt   <= wr_cnt + 1;
         wr_addr  <= db_addr;
         wr_lanes <= db_lanes;
         wr_dout  <= db_dout;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0013;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic snap();
      b_jmp = jmp_cnt;
      b_rt  = rt_cnt;
      b_wr  = wr_cnt;
   endtask

   initial begin
      rom_en  = 1'b1;
      db_ready = 1'b1;
      db_din  = '0;

      // 1: addi/addi/add/sw
      clear_rom();
      rom[0] = enc_i(5, 0, 3'd0, 5, 7'h13);
      rom[1] = enc_i(-2, 5, 3'd0, 6, 7'h13);
      rom[2] = enc_r(7'h00, 6, 5, 3'd0, 7);
      rom[3] = enc_s(0, 7, 0, 3'd2);
      do_reset();
      snap();
      check("reset_ib_valid", ib_valid, 32'd0);
      check("reset_db_valid", db_valid, 32'd0);
      check("reset_r5", r5, 32'd0);
      check("reset_r10", r10, 32'd0);
      repeat (60) @(negedge clk);
      check("t1_r5", r5, 32'd5);
      check("t1_r6", r6, 32'd3);
      check("t1_r7", r7, 32'd8);
      check("t1_nwrites", wr_cnt - b_wr, 32'd1);
      check("t1_wr_addr", wr_addr, 32'h0);
      check("t1_wr_lanes", wr_lanes, 32'hF);
      check("t1_wr_dout", wr_dout, 32'h8);

      // 2: dependent addi chain on x10
      clear_rom();
      for (int i = 0; i < 10; i++) rom[i] = enc_i(1, 10, 3'd0, 10, 7'h13);
      do_reset();
      repeat (80) @(negedge clk);
      check("t2_r10", r10, 32'd10);

      // 3: taken beq skips two addi x5
      clear_rom();
      rom[0] = enc_b(12, 0, 0, 3'd0);
      rom[1] = enc_i(1, 0, 3'd0, 5, 7'h13);
      rom[2] = enc_i(1, 0, 3'd0, 5, 7'h13);
      do_reset();
      snap();
      repeat (40) @(negedge clk);
      check("t3_jmp_count", jmp_cnt - b_jmp, 32'd1);
      check("t3_jmp_addr", last_jmp, 32'd12);
      check("t3_r5", r5, 32'd0);

      // 4: sb then lb of the top byte
      clear_rom();
      db_din = 32'hAB00_0000;
      rom[0] = enc_i(32'hAB, 0, 3'd0, 6, 7'h13);
      rom[1] = enc_s(3, 6, 0, 3'd0);
      rom[2] = enc_i(3, 0, 3'd0, 7, 7'h03);
      do_reset();
      snap();
      repeat (60) @(negedge clk);
      check("t4_r6", r6, 32'hAB);
      check("t4_nwrites", wr_cnt - b_wr, 32'd1);
      check("t4_wr_lanes", wr_lanes, 32'h8);
      check("t4_wr_dout", wr_dout, 32'hABAB_ABAB);
      check("t4_r7", r7, 32'hFFFF_FFAB);

      // 5: lui/addi, then jal over one slot
      clear_rom();
      rom[0] = {20'h12345, 5'd10, 7'h37};
      rom[1] = enc_i(32'h678, 10, 3'd0, 10, 7'h13);
      rom[2] = enc_j(8, 5);
      rom[3] = enc_i(1, 0, 3'd0, 6, 7'h13);
      do_reset();
      snap();
      repeat (60) @(negedge clk);
      check("t5_r10", r10, 32'h1234_5678);
      check("t5_r5_link", r5, 32'd12);
      check("t5_skipped_r6", r6, 32'd0);
      check("t5_jmp_addr", last_jmp, 32'd16);

      // 6: fetch starved, then reset during a pending store
      clear_rom();
      rom[0] = enc_i(7, 0, 3'd0, 5, 7'h13);
      rom[1] = enc_s(4, 5, 0, 3'd2);
      rom_en = 1'b0;
      db_ready = 1'b0;
      do_reset();
      snap();
      repeat (6) @(negedge clk);
      check("t6_no_retire", rt_cnt - b_rt, 32'd0);
      check("t6_ib_hold_valid", ib_valid, 32'd1);
      check("t6_ib_hold_addr", ib_addr, 32'd0);
      rom_en = 1'b1;
      repeat (30) @(negedge clk);
      check("t6_r5", r5, 32'd7);
      check("t6_store_pending", db_valid, 32'd1);
      check("t6_store_addr", db_addr, 32'd4);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_rst_db_valid", db_valid, 32'd0);
      check("t6_rst_ib_valid", ib_valid, 32'd0);
      check("t6_rst_r5", r5, 32'd0);
      check("t6_no_write", wr_cnt - b_wr, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("t6_refetch_valid", ib_valid, 32'd1);
      check("t6_refetch_addr", ib_addr, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
